// File: rtl/tl_fragmenter_pipe_if.sv
// tl_fragmenter_pipe_if: TL-UL A/D channel bundle; master drives A and sinks D.
interface tl_fragmenter_pipe_if #(
  parameter int AW = 17,
  parameter int SW = 6,
  parameter int DW = 64
);
  logic          a_ready;
  logic          a_valid;
  logic [2:0]    a_opcode;
  logic [2:0]    a_param;
  logic [2:0]    a_size;
  logic [SW-1:0] a_source;
  logic [AW-1:0] a_address;
  logic [DW/8-1:0] a_mask;
  logic [DW-1:0] a_data;
  logic          a_corrupt;
  logic          d_ready;
  logic          d_valid;
  logic [2:0]    d_opcode;
  logic [2:0]    d_size;
  logic [SW-1:0] d_source;
  logic [DW-1:0] d_data;
  modport master (
    output a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, a_corrupt, d_ready,
    input  a_ready, d_valid, d_opcode, d_size, d_source, d_data
  );
  modport slave (
    input  a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, a_corrupt, d_ready,
    output a_ready, d_valid, d_opcode, d_size, d_source, d_data
  );
endinterface

// File: rtl/tl_fragmenter_pipe.sv
// tl_fragmenter_pipe: splits multi-beat TL-UL Get/Put into single-beat requests, merges Put acks on D.
module tl_fragmenter_pipe #(
  parameter int ADDR_W     = 17,
  parameter int SRC_W      = 6,
  parameter int BEAT_BYTES = 8,
  parameter int MAX_BYTES  = 64,
  parameter bit A_PIPE     = 1
) (
  input  logic clk_i,
  input  logic rst_ni,
  tl_fragmenter_pipe_if.slave  in_if,
  tl_fragmenter_pipe_if.master out_if
);
  localparam int DW     = 8 * BEAT_BYTES;
  localparam int BL     = $clog2(BEAT_BYTES);
  localparam int FW     = (MAX_BYTES > BEAT_BYTES) ? $clog2(MAX_BYTES / BEAT_BYTES) : 1;
  localparam int SZW    = 3;
  localparam int OSRC_W = SRC_W + SZW + FW;
  localparam int PW     = 9 + OSRC_W + ADDR_W + BEAT_BYTES + DW + 1;
  typedef enum logic {IDLE, BURST} state_e;
  state_e state_q, state_d;
  logic [FW-1:0] idx_q, idx_d, idx, last_idx, cnt;
  logic big, is_get, last, f_ready, fire, pv_valid, drop;
  logic [PW-1:0] frag, pv;
  always_comb begin
    idx      = (state_q == BURST) ? idx_q : '0;
    big      = in_if.a_size > 3'(BL);
    last_idx = big ? FW'((32'd1 << (32'(in_if.a_size) - 32'(BL))) - 32'd1) : '0;
    cnt      = last_idx - idx;
    is_get   = in_if.a_opcode == 3'd4;
    last     = idx == last_idx;
    fire     = rst_ni && in_if.a_valid && f_ready;
    in_if.a_ready = rst_ni && f_ready && (!is_get || last);
    idx_d    = fire ? (last ? '0 : idx + FW'(1)) : idx;
    state_d  = fire ? (last ? IDLE : BURST) : state_q;
    frag     = {in_if.a_opcode, in_if.a_param, big ? 3'(BL) : in_if.a_size,
                in_if.a_source, in_if.a_size, cnt,
                in_if.a_address | (ADDR_W'(idx) << BL),
                (is_get && big) ? {BEAT_BYTES{1'b1}} : in_if.a_mask,
                in_if.a_data, in_if.a_corrupt};
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end
  if (A_PIPE) begin : g_pipe
    logic s_valid_q;
    logic [PW-1:0] s_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        s_valid_q <= 1'b0;
        s_q       <= '0;
      end else begin
        s_valid_q <= f_ready ? in_if.a_valid : s_valid_q;
        s_q       <= fire ? frag : s_q;
      end
    end
    assign f_ready  = !s_valid_q || out_if.a_ready;
    assign pv_valid = s_valid_q;
    assign pv       = s_q;
  end else begin : g_pass
    assign f_ready  = out_if.a_ready;
    assign pv_valid = rst_ni && in_if.a_valid;
    assign pv       = frag;
  end
  assign out_if.a_valid = pv_valid;
  assign {out_if.a_opcode, out_if.a_param, out_if.a_size, out_if.a_source, out_if.a_address,
          out_if.a_mask, out_if.a_data, out_if.a_corrupt} = pv;
  // Non-final Put acks are swallowed so the master sees one ack per burst
  assign drop            = (out_if.d_opcode == 3'd0) && (out_if.d_source[FW-1:0] != '0);
  assign in_if.d_valid   = out_if.d_valid && !drop;
  assign out_if.d_ready  = drop || in_if.d_ready;
  assign in_if.d_opcode  = out_if.d_opcode;
  assign in_if.d_size    = out_if.d_source[FW +: SZW];
  assign in_if.d_source  = out_if.d_source[OSRC_W-1 -: SRC_W];
  assign in_if.d_data    = out_if.d_data;
  logic unused_d_size;
  assign unused_d_size = ^out_if.d_size;
endmodule

// File: tb/tb_tl_fragmenter_pipe.sv
// tb_tl_fragmenter_pipe: directed checks of fragmentation, Put-ack merge, backpressure and reset.
module tb_tl_fragmenter_pipe;
  logic clk, rst_ni;
  int total = 0, bad = 0, nin = 0;
  bit tog = 0;
  logic [16:0] qa[$];
  logic [11:0] qs[$];
  logic [7:0]  qm[$];
  logic [2:0]  qz[$];
  logic [63:0] qd[$];
  tl_fragmenter_pipe_if #(.AW(17), .SW(6),  .DW(64)) tin();
  tl_fragmenter_pipe_if #(.AW(17), .SW(12), .DW(64)) tout();
  tl_fragmenter_pipe #(.ADDR_W(17), .SRC_W(6), .BEAT_BYTES(8), .MAX_BYTES(64), .A_PIPE(1)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .in_if(tin), .out_if(tout));
  initial clk = 0;
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (rst_ni && tout.a_valid && tout.a_ready) begin
      qa.push_back(tout.a_address);
      qs.push_back(tout.a_source);
      qm.push_back(tout.a_mask);
      qz.push_back(tout.a_size);
      qd.push_back(tout.a_data);
    end
    if (rst_ni && tin.a_valid && tin.a_ready) nin++;
  end
  initial begin
    #200000;
    $error("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end
  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic clr();
    qa.delete(); qs.delete(); qm.delete(); qz.delete(); qd.delete();
    nin = 0;
  endtask
  task automatic send(input logic [2:0] op, input logic [2:0] sz, input logic [16:0] ad,
                      input logic [5:0] s, input logic [7:0] m, input logic [63:0] d);
    logic ok;
    tin.a_opcode = op; tin.a_size = sz; tin.a_address = ad; tin.a_source = s;
    tin.a_mask = m; tin.a_data = d; tin.a_valid = 1;
    ok = 0;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge clk);
      if (tin.a_valid && tin.a_ready) ok = 1;
      else begin
        step();
        if (tog) tout.a_ready = !tout.a_ready;
      end
    end
    chk("a_handshake", ok, 1);
    step();
    tin.a_valid = 0;
  endtask
  initial begin
    logic ok;
    rst_ni = 0;
    tin.a_valid = 0; tin.a_opcode = 0; tin.a_param = 0; tin.a_size = 0; tin.a_source = 0;
    tin.a_address = 0; tin.a_mask = 0; tin.a_data = 0; tin.a_corrupt = 0; tin.d_ready = 1;
    tout.a_ready = 1; tout.d_valid = 0; tout.d_opcode = 0; tout.d_size = 0;
    tout.d_source = 0; tout.d_data = 0;
    #2;
    chk("rst_out_a_valid", tout.a_valid, 0);
    chk("rst_in_a_ready", tin.a_ready, 0);
    step(); step();
    rst_ni = 1;
    #1;
    chk("idle_out_a_valid", tout.a_valid, 0);
    clr();
    send(3'd4, 3'd6, 17'h100, 6'd5, 8'h00, 64'h0);
    repeat (3) step();
    chk("get_count", qa.size(), 8);
    chk("get_in_hs", nin, 1);
    for (int i = 0; i < qa.size(); i++) begin
      chk("get_addr", qa[i], 'h100 + 8 * i);
      chk("get_src", qs[i], (5 << 6) | (6 << 3) | (7 - i));
      chk("get_size", qz[i], 3);
      chk("get_mask", qm[i], 'hFF);
    end
    clr();
    for (int i = 0; i < 4; i++) send(3'd0, 3'd5, 17'h40, 6'd3, 8'hFF, 64'hA0 + i);
    repeat (3) step();
    chk("put_count", qa.size(), 4);
    chk("put_in_hs", nin, 4);
    for (int i = 0; i < qa.size(); i++) begin
      chk("put_addr", qa[i], 'h40 + 8 * i);
      chk("put_src", qs[i], (3 << 6) | (5 << 3) | (3 - i));
      chk("put_data", qd[i], 'hA0 + i);
    end
    for (int i = 0; i < 4; i++) begin
      tout.d_valid = 1; tout.d_opcode = 0; tout.d_source = 12'((3 << 6) | (5 << 3) | (3 - i));
      #1;
      if (i < 3) begin
        chk("put_d_drop_ready", tout.d_ready, 1);
        chk("put_d_drop_valid", tin.d_valid, 0);
      end else begin
        chk("put_d_last_valid", tin.d_valid, 1);
        chk("put_d_size", tin.d_size, 5);
        chk("put_d_src", tin.d_source, 3);
        chk("put_d_opcode", tin.d_opcode, 0);
      end
      step();
    end
    tout.d_valid = 0;
    clr();
    send(3'd4, 3'd2, 17'h14, 6'd4, 8'hF0, 64'h0);
    repeat (3) step();
    chk("small_count", qa.size(), 1);
    chk("small_addr", qa[0], 'h14);
    chk("small_size", qz[0], 2);
    chk("small_mask", qm[0], 'hF0);
    chk("small_src", qs[0], 272);
    tout.d_valid = 1; tout.d_opcode = 1; tout.d_source = 12'd272; tout.d_data = 64'hDEADBEEF01234567;
    #1;
    chk("small_d_valid", tin.d_valid, 1);
    chk("small_d_opcode", tin.d_opcode, 1);
    chk("small_d_size", tin.d_size, 2);
    chk("small_d_src", tin.d_source, 4);
    chk("small_d_data", tin.d_data, 64'hDEADBEEF01234567);
    step();
    tout.d_valid = 0;
    clr();
    tog = 1;
    send(3'd4, 3'd6, 17'h80, 6'd6, 8'h00, 64'h0);
    tog = 0;
    tout.a_ready = 1;
    repeat (4) step();
    chk("tog_count", qa.size(), 8);
    for (int i = 0; i < qa.size(); i++) begin
      chk("tog_addr", qa[i], 'h80 + 8 * i);
      chk("tog_src", qs[i], (6 << 6) | (6 << 3) | (7 - i));
    end
    clr();
    tin.a_opcode = 4; tin.a_size = 6; tin.a_address = 17'h200; tin.a_source = 2; tin.a_valid = 1;
    ok = 0;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      #1;
      if (qa.size() >= 3) ok = 1;
    end
    chk("rst_reach_idx3", ok, 1);
    step();
    rst_ni = 0;
    #1;
    chk("midrst_out_a_valid", tout.a_valid, 0);
    chk("midrst_in_a_ready", tin.a_ready, 0);
    tin.a_valid = 0;
    step();
    rst_ni = 1;
    clr();
    send(3'd4, 3'd4, 17'h300, 6'd9, 8'h00, 64'h0);
    repeat (3) step();
    chk("post_rst_count", qa.size(), 2);
    chk("post_rst_addr0", qa[0], 'h300);
    chk("post_rst_src0", qs[0], (9 << 6) | (4 << 3) | 1);
    chk("post_rst_addr1", qa[1], 'h308);
    chk("post_rst_src1", qs[1], (9 << 6) | (4 << 3));
    tin.d_ready = 0;
    tout.d_valid = 1; tout.d_opcode = 1; tout.d_source = 12'((7 << 6) | (6 << 3) | 2);
    tout.d_data = 64'h55AA55AA12345678;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_out_d_ready", tout.d_ready, 0);
      chk("bp_in_d_valid", tin.d_valid, 1);
      chk("bp_in_d_data", tin.d_data, 64'h55AA55AA12345678);
      step();
    end
    tin.d_ready = 1;
    #1;
    chk("bp_release_ready", tout.d_ready, 1);
    chk("bp_release_src", tin.d_source, 7);
    chk("bp_release_size", tin.d_size, 6);
    step();
    tout.d_valid = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
